// File: rtl/regwrite_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter.
// Address/data widths and the mult/div FIFO entry layout.
package regwrite_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } md_entry_t;

endpackage

// File: rtl/md_result_fifo.sv
// Small synchronous FIFO holding mult/div results awaiting a write slot.
// Push while full is accepted only when a pop frees the slot that same cycle.
module md_result_fifo
  import regwrite_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_push,
  input  logic      i_pop,
  input  md_entry_t i_din,
  output md_entry_t o_dout,
  output logic      o_full,
  output logic      o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  md_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rd];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr] <= i_din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= r_wr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/regwrite_arbiter.sv
// Owns the regfile write port: merges pipeline write-back with buffered
// mult/div results, tracks pending destinations and prevents FIFO starvation.
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  wb_stall,
  input  logic                  md_issue,
  input  logic [REG_ADDR_W-1:0] md_issue_rd,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0]     md_data,
  output logic                  md_ready,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0]     data_writeReg
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic                  r_stall;
  logic [SW-1:0]         r_starve;
  logic [NUM_REGS-1:0]   r_busy;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]     r_data;

  logic                  w_full;
  logic                  w_empty;
  md_entry_t             w_head;
  md_entry_t             w_push_ent;
  logic                  w_live;
  logic                  w_md_acc;
  logic                  w_md_zero;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_sel_we;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [DATA_W-1:0]     w_sel_data;
  logic [NUM_REGS-1:0]   w_clr;
  logic [NUM_REGS-1:0]   w_set;
  logic [SW-1:0]         w_starve_nxt;
  logic                  w_stall_nxt;

  assign w_live    = wb_valid && (wb_rd != '0) && !r_stall;
  assign w_md_acc  = md_valid && !w_full;
  assign w_md_zero = (md_rd == '0);

  assign w_push_ent.rd   = md_rd;
  assign w_push_ent.data = md_data;

  md_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (ctrl_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_ent),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Write-slot priority: live pipeline, then FIFO head, then md bypass.
  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_rd   = wb_rd;
    w_sel_data = wb_data;
    w_pop      = 1'b0;
    w_bypass   = 1'b0;
    w_push     = 1'b0;
    w_clr      = '0;
    if (w_live) begin
      w_sel_we = 1'b1;
    end else if (!w_empty) begin
      w_sel_we          = 1'b1;
      w_pop             = 1'b1;
      w_sel_rd          = w_head.rd;
      w_sel_data        = w_head.data;
      w_clr[w_head.rd]  = 1'b1;
    end else if (w_md_acc && !w_md_zero) begin
      w_sel_we        = 1'b1;
      w_bypass        = 1'b1;
      w_sel_rd        = md_rd;
      w_sel_data      = md_data;
      w_clr[md_rd]    = 1'b1;
    end
    if (w_md_acc && !w_md_zero && !w_bypass) begin
      w_push = 1'b1;
    end
    if (w_md_acc && w_md_zero) begin
      w_clr[0] = 1'b1;
    end
  end

  // Scoreboard set on issue of a non-zero destination.
  always_comb begin
    w_set = '0;
    if (md_issue && (md_issue_rd != '0)) begin
      w_set[md_issue_rd] = 1'b1;
    end
  end

  // Count cycles a full FIFO is blocked by live pipeline traffic.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || !w_full) begin
      w_starve_nxt = '0;
    end else if (w_live && (r_starve != SW'(STARVE_LIMIT))) begin
      w_starve_nxt = r_starve + SW'(1);
    end
    w_stall_nxt = (w_starve_nxt == SW'(STARVE_LIMIT));
  end

  // Control state: stall pulse, starve counter, scoreboard, write enable.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_stall  <= 1'b0;
      r_starve <= '0;
      r_busy   <= '0;
      r_we     <= 1'b0;
    end else begin
      r_stall  <= w_stall_nxt;
      r_starve <= w_starve_nxt;
      r_busy   <= (r_busy & ~w_clr) | w_set;
      r_we     <= w_sel_we;
    end
  end

  // Write address/data hold their last value when no write is selected.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_rd   <= '0;
      r_data <= '0;
    end else if (w_sel_we) begin
      r_rd   <= w_sel_rd;
      r_data <= w_sel_data;
    end
  end

  assign wb_stall         = r_stall;
  assign md_ready         = !w_full;
  assign busy             = r_busy;
  assign ctrl_writeEnable = r_we;
  assign ctrl_writeReg    = r_rd;
  assign data_writeReg    = r_data;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter with a write-order scoreboard.
// Expected regfile writes are queued as stimulus is driven.
module tb_regwrite_arbiter;
  import regwrite_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic [31:0] busy;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int n_cmp = 0;
  int n_bad = 0;
  md_entry_t exp_q[$];
  md_entry_t m_e;

  regwrite_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .wb_stall         (wb_stall),
    .md_issue         (md_issue),
    .md_issue_rd      (md_issue_rd),
    .md_valid         (md_valid),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .md_ready         (md_ready),
    .busy             (busy),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  always @(negedge clock) begin
    if (ctrl_writeEnable === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_bad++;
        $error("FAIL unexpected_write obs rd=%0d data=%h exp none",
               ctrl_writeReg, data_writeReg);
      end
      if (exp_q.size() > 0) begin
        m_e = exp_q.pop_front();
        n_cmp++;
        assert ({ctrl_writeReg, data_writeReg} === {m_e.rd, m_e.data})
        else begin
          n_bad++;
          $error("FAIL write obs rd=%0d data=%h exp rd=%0d data=%h",
                 ctrl_writeReg, data_writeReg, m_e.rd, m_e.data);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic wv, input logic [4:0] wr,
                     input logic [31:0] wd, input logic mv,
                     input logic [4:0] mr, input logic [31:0] mdd,
                     input logic iss, input logic [4:0] ir);
    wb_valid    = wv;
    wb_rd       = wr;
    wb_data     = wd;
    md_valid    = mv;
    md_rd       = mr;
    md_data     = mdd;
    md_issue    = iss;
    md_issue_rd = ir;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic expw(input logic [4:0] rd, input logic [31:0] d);
    md_entry_t e;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  initial begin
    ctrl_reset = 1'b1;
    idle();
    tick();
    tick();
    ctrl_reset = 1'b0;
    neg();
    chk("rst_we", {31'b0, ctrl_writeEnable}, 0);
    chk("rst_rd", {27'b0, ctrl_writeReg}, 0);
    chk("rst_data", data_writeReg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", {31'b0, wb_stall}, 0);
    chk("rst_mdrdy", {31'b0, md_ready}, 1);
    tick();

    // pipeline write
    drv(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    expw(5, 32'hDEADBEEF);
    tick();
    idle();
    neg();
    chk("wb_busy", busy, 0);
    tick();

    // md bypass
    drv(0, 0, 0, 1, 7, 32'h12, 0, 0);
    expw(7, 32'h12);
    neg();
    chk("byp_rdy0", {31'b0, md_ready}, 1);
    tick();
    idle();
    neg();
    chk("byp_rdy1", {31'b0, md_ready}, 1);
    tick();

    // buffered md result and scoreboard
    drv(1, 1, 32'h100, 0, 0, 0, 1, 9);
    expw(1, 32'h100);
    tick();
    drv(1, 2, 32'h200, 1, 9, 32'h55, 0, 0);
    expw(2, 32'h200);
    neg();
    chk("sb_set", busy, 32'h200);
    tick();
    drv(1, 3, 32'h300, 0, 0, 0, 0, 0);
    expw(3, 32'h300);
    neg();
    chk("sb_hold", busy, 32'h200);
    chk("fifo1_rdy", {31'b0, md_ready}, 1);
    tick();
    idle();
    expw(9, 32'h55);
    neg();
    chk("sb_pre_clr", busy, 32'h200);
    tick();
    neg();
    chk("sb_clr", busy, 0);
    tick();

    // fill FIFO under full pipeline load, then starvation steal
    drv(1, 10, 32'hA0, 1, 11, 32'hB1, 0, 0);
    expw(10, 32'hA0);
    neg();
    chk("fill_rdy0", {31'b0, md_ready}, 1);
    tick();
    drv(1, 12, 32'hA1, 1, 13, 32'hB3, 0, 0);
    expw(12, 32'hA1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drv(1, 5'(14 + i), 32'hC3 + 32'(i), 0, 0, 0, 0, 0);
      expw(5'(14 + i), 32'hC3 + 32'(i));
      neg();
      chk("full_rdy", {31'b0, md_ready}, 0);
      chk("no_stall", {31'b0, wb_stall}, 0);
      tick();
    end
    drv(1, 18, 32'hC7, 0, 0, 0, 0, 0);
    expw(11, 32'hB1);
    neg();
    chk("stall_hi", {31'b0, wb_stall}, 1);
    chk("stall_rdy", {31'b0, md_ready}, 0);
    tick();
    expw(18, 32'hC7);
    neg();
    chk("stall_lo", {31'b0, wb_stall}, 0);
    chk("drain_rdy", {31'b0, md_ready}, 1);
    tick();
    idle();
    expw(13, 32'hB3);
    tick();
    neg();
    chk("drain_empty_rdy", {31'b0, md_ready}, 1);
    tick();

    // register 0 handling
    drv(1, 0, 32'hBAD, 1, 3, 32'h33, 0, 0);
    expw(3, 32'h33);
    tick();
    drv(0, 0, 0, 1, 0, 32'h77, 0, 0);
    neg();
    chk("rd0_rdy", {31'b0, md_ready}, 1);
    tick();
    idle();
    neg();
    chk("rd0_no_we", {31'b0, ctrl_writeEnable}, 0);
    chk("rd0_busy", busy, 0);
    tick();

    // reset mid-operation
    drv(1, 20, 32'hE0, 1, 21, 32'hF1, 1, 9);
    expw(20, 32'hE0);
    tick();
    drv(1, 22, 32'hE1, 1, 23, 32'hF2, 1, 10);
    expw(22, 32'hE1);
    tick();
    drv(1, 24, 32'hE2, 0, 0, 0, 0, 0);
    ctrl_reset = 1'b1;
    neg();
    chk("pre_rst_busy", busy, 32'h600);
    chk("pre_rst_rdy", {31'b0, md_ready}, 0);
    tick();
    ctrl_reset = 1'b0;
    idle();
    neg();
    chk("mid_rst_we", {31'b0, ctrl_writeEnable}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", {31'b0, md_ready}, 1);
    tick();
    drv(1, 25, 32'hE5, 0, 0, 0, 0, 0);
    expw(25, 32'hE5);
    tick();
    idle();
    tick();
    tick();
    neg();
    chk("post_rst_we", {31'b0, ctrl_writeEnable}, 0);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
